// File: rtl/id_stage_fwd_if.sv
// ID/EX pipeline register bundle presented to the execute unit.
// master drives the registered fields; slave is the execute-side view.
interface id_stage_fwd_if #(
   parameter int unsigned DW = 32
) ();
   logic [7:0]    aluop;
   logic [2:0]    alusel;
   logic [DW-1:0] reg1;
   logic [DW-1:0] reg2;
   logic [4:0]    wd;
   logic          wreg;
   logic          is_load;
   logic [31:0]   pc;
   logic          inst_invalid;

   modport master (
      output aluop, alusel, reg1, reg2, wd, wreg, is_load, pc, inst_invalid
   );

   modport slave (
      input aluop, alusel, reg1, reg2, wd, wreg, is_load, pc, inst_invalid
   );
endinterface

// File: rtl/id_stage_fwd.sv
// Decode stage with ID/EX register, FWD_N-source operand forwarding and load-use bubbles.
// Load-use stall logic is enabled by defining ID_LOAD_USE_EN (default: stallreq_o tied 0).
module id_stage_fwd #(
   parameter int unsigned DW    = 32,
   parameter int unsigned FWD_N = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_i,
   input  logic                flush_i,
   input  logic [31:0]         pc_i,
   input  logic [31:0]         inst_i,
   input  logic [DW-1:0]       reg1_data_i,
   input  logic [DW-1:0]       reg2_data_i,
   output logic [4:0]          reg1_addr_o,
   output logic [4:0]          reg2_addr_o,
   output logic                reg1_read_o,
   output logic                reg2_read_o,
   input  logic [5*FWD_N-1:0]  fwd_wd_i,
   input  logic [FWD_N-1:0]    fwd_wreg_i,
   input  logic [DW*FWD_N-1:0] fwd_wdata_i,
   output logic                stallreq_o,
   id_stage_fwd_if.master      ex_o
);

   localparam logic [7:0] AluNop   = 8'h00;
   localparam logic [7:0] AluAnd   = 8'b0010_0100;
   localparam logic [7:0] AluOr    = 8'b0010_0101;
   localparam logic [7:0] AluXor   = 8'b0010_0110;
   localparam logic [7:0] AluLw    = 8'b1110_0011;
   localparam logic [2:0] ResLogic = 3'b001;
   localparam logic [2:0] ResLdSt  = 3'b111;

   typedef struct packed {
      logic [7:0]    aluop;
      logic [2:0]    alusel;
      logic [DW-1:0] reg1;
      logic [DW-1:0] reg2;
      logic [4:0]    wd;
      logic          wreg;
      logic          is_load;
      logic [31:0]   pc;
      logic          inst_invalid;
   } idex_t;

   idex_t idex_q, idex_d, dec, bubble;

   logic [5:0]    op, funct;
   logic [4:0]    rs, rt, rd, shamt;
   logic [15:0]   imm16;
   logic [DW-1:0] imm;
   logic          read1, read2;

   assign op    = inst_i[31:26];
   assign rs    = inst_i[25:21];
   assign rt    = inst_i[20:16];
   assign rd    = inst_i[15:11];
   assign shamt = inst_i[10:6];
   assign funct = inst_i[5:0];
   assign imm16 = inst_i[15:0];

   always_comb begin
      dec   = '0;
      dec.pc = pc_i;
      read1 = 1'b0;
      read2 = 1'b0;
      imm   = '0;
      unique case (op)
         6'b000000: begin
            if (shamt == 5'd0 && funct[5:2] == 4'b1001) begin
               dec.aluop  = {2'b00, funct};
               dec.alusel = ResLogic;
               dec.wd     = rd;
               dec.wreg   = 1'b1;
               read1      = 1'b1;
               read2      = 1'b1;
            end else begin
               dec.inst_invalid = 1'b1;
            end
         end
         6'b001100, 6'b001101, 6'b001110: begin
            dec.aluop  = (op == 6'b001100) ? AluAnd : (op == 6'b001101) ? AluOr : AluXor;
            dec.alusel = ResLogic;
            dec.wd     = rt;
            dec.wreg   = 1'b1;
            read1      = 1'b1;
            imm        = DW'(imm16);
         end
         6'b001111: begin
            dec.aluop  = AluOr;
            dec.alusel = ResLogic;
            dec.wd     = rt;
            dec.wreg   = 1'b1;
            read1      = 1'b1;
            imm        = DW'({imm16, 16'h0000});
         end
         6'b100011: begin
            dec.aluop   = AluLw;
            dec.alusel  = ResLdSt;
            dec.wd      = rt;
            dec.wreg    = 1'b1;
            dec.is_load = 1'b1;
            read1       = 1'b1;
            imm         = DW'($signed(imm16));
         end
         default: begin
            dec.aluop        = AluNop;
            dec.inst_invalid = 1'b1;
         end
      endcase
      // Register file reads are suppressed while reset is asserted.
      if (!rst) begin
         read1 = 1'b0;
         read2 = 1'b0;
      end

      // Descending scan so the lowest (youngest) matching slot wins.
      if (read1) begin
         dec.reg1 = reg1_data_i;
         for (int k = FWD_N - 1; k >= 0; k--) begin
            if (fwd_wreg_i[k] && fwd_wd_i[5*k +: 5] == rs && rs != 5'd0) begin
               dec.reg1 = fwd_wdata_i[DW*k +: DW];
            end
         end
      end
      if (read2) begin
         dec.reg2 = reg2_data_i;
         for (int k = FWD_N - 1; k >= 0; k--) begin
            if (fwd_wreg_i[k] && fwd_wd_i[5*k +: 5] == rt && rt != 5'd0) begin
               dec.reg2 = fwd_wdata_i[DW*k +: DW];
            end
         end
      end else begin
         dec.reg2 = imm;
      end
   end

   assign reg1_addr_o = rs;
   assign reg2_addr_o = rt;
   assign reg1_read_o = read1;
   assign reg2_read_o = read2;

`ifdef ID_LOAD_USE_EN
   assign stallreq_o = idex_q.is_load & idex_q.wreg & (idex_q.wd != 5'd0) &
                       ((read1 & (rs == idex_q.wd)) | (read2 & (rt == idex_q.wd)));
`else
   assign stallreq_o = 1'b0;
`endif

   always_comb begin
      bubble    = '0;
      bubble.pc = pc_i;
      if (flush_i) begin
         idex_d = bubble;
      end else if (stall_i) begin
         idex_d = idex_q;
      end else if (stallreq_o) begin
         idex_d = bubble;
      end else begin
         idex_d = dec;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_d;
      end
   end

   assign ex_o.aluop        = idex_q.aluop;
   assign ex_o.alusel       = idex_q.alusel;
   assign ex_o.reg1         = idex_q.reg1;
   assign ex_o.reg2         = idex_q.reg2;
   assign ex_o.wd           = idex_q.wd;
   assign ex_o.wreg         = idex_q.wreg;
   assign ex_o.is_load      = idex_q.is_load;
   assign ex_o.pc           = idex_q.pc;
   assign ex_o.inst_invalid = idex_q.inst_invalid;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Scoreboard bench for id_stage_fwd: directed vectors push expected EX contents,
// a monitor pops and compares stallreq_o mid-cycle and the ID/EX register after each edge.
module tb_id_stage_fwd;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, flush_i;
   logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i;
   logic [4:0]  reg1_addr_o, reg2_addr_o;
   logic        reg1_read_o, reg2_read_o;
   logic [9:0]  fwd_wd_i;
   logic [1:0]  fwd_wreg_i;
   logic [63:0] fwd_wdata_i;
   logic        stallreq_o;

   id_stage_fwd_if #(.DW(32)) ex_if ();

   id_stage_fwd #(.DW(32), .FWD_N(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .pc_i        (pc_i),
      .inst_i      (inst_i),
      .reg1_data_i (reg1_data_i),
      .reg2_data_i (reg2_data_i),
      .reg1_addr_o (reg1_addr_o),
      .reg2_addr_o (reg2_addr_o),
      .reg1_read_o (reg1_read_o),
      .reg2_read_o (reg2_read_o),
      .fwd_wd_i    (fwd_wd_i),
      .fwd_wreg_i  (fwd_wreg_i),
      .fwd_wdata_i (fwd_wdata_i),
      .stallreq_o  (stallreq_o),
      .ex_o        (ex_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        stall;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic        is_load;
      logic [31:0] pc;
      logic        inv;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
`ifdef ID_LOAD_USE_EN
   localparam bit HazEn = 1'b1;
`else
   localparam bit HazEn = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic exp_t mk(input logic st, input logic [7:0] aluop, input logic [2:0] sel,
                               input logic [31:0] r1, r2, input logic [4:0] wd,
                               input logic wreg, ld, input logic [31:0] pc, input logic inv);
      exp_t e;
      e = '{stall: st, aluop: aluop, alusel: sel, reg1: r1, reg2: r2, wd: wd, wreg: wreg,
            is_load: ld, pc: pc, inv: inv};
      return e;
   endfunction

   // Called just after a rising edge; returns just after the next one.
   task automatic drive(input logic [31:0] inst, pc, r1d, r2d, input logic [9:0] wd,
                        input logic [1:0] wreg, input logic [63:0] wdata,
                        input logic st, fl, input exp_t e);
      inst_i = inst; pc_i = pc; reg1_data_i = r1d; reg2_data_i = r2d;
      fwd_wd_i = wd; fwd_wreg_i = wreg; fwd_wdata_i = wdata;
      stall_i = st; flush_i = fl;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("stallreq", 32'(stallreq_o), 32'(mon_e.stall));
            @(posedge clk);
            #2;
            chk("aluop",   32'(ex_if.aluop),        32'(mon_e.aluop));
            chk("alusel",  32'(ex_if.alusel),       32'(mon_e.alusel));
            chk("reg1",    ex_if.reg1,              mon_e.reg1);
            chk("reg2",    ex_if.reg2,              mon_e.reg2);
            chk("wd",      32'(ex_if.wd),           32'(mon_e.wd));
            chk("wreg",    32'(ex_if.wreg),         32'(mon_e.wreg));
            chk("is_load", 32'(ex_if.is_load),      32'(mon_e.is_load));
            chk("pc",      ex_if.pc,                mon_e.pc);
            chk("invalid", 32'(ex_if.inst_invalid), 32'(mon_e.inv));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t held;
      rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; pc_i = 32'h0;
      inst_i = enc_i(6'b001101, 5'd1, 5'd1, 16'h1); reg1_data_i = '0; reg2_data_i = '0;
      fwd_wd_i = '0; fwd_wreg_i = '0; fwd_wdata_i = '0;
      #2;
      chk("rst_wreg",  32'(ex_if.wreg), 32'd0);
      chk("rst_read1", 32'(reg1_read_o), 32'd0);
      chk("rst_stall", 32'(stallreq_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // ORI r1, r0, 0x1234
      drive(enc_i(6'b001101, 5'd0, 5'd1, 16'h1234), 32'h100, 32'h0, 32'h0, '0, 2'b00, '0,
            1'b0, 1'b0, mk(0, 8'h25, 3'd1, 32'h0, 32'h1234, 5'd1, 1, 0, 32'h100, 0));
      // OR r2, r1, r1 with r1 forwarded from EX
      drive(enc_r(5'd1, 5'd1, 5'd2, 6'h25), 32'h104, 32'hDEAD, 32'hDEAD, {5'd0, 5'd1}, 2'b01,
            {32'h0, 32'h1234}, 1'b0, 1'b0,
            mk(0, 8'h25, 3'd1, 32'h1234, 32'h1234, 5'd2, 1, 0, 32'h104, 0));
      // XOR r8, r3, r3: both slots hit, slot 0 wins
      drive(enc_r(5'd3, 5'd3, 5'd8, 6'h26), 32'h108, 32'h33, 32'h33, {5'd3, 5'd3}, 2'b11,
            {32'hB, 32'hA}, 1'b0, 1'b0,
            mk(0, 8'h26, 3'd1, 32'hA, 32'hA, 5'd8, 1, 0, 32'h108, 0));
      // slot 0 not writing -> slot 1
      drive(enc_r(5'd3, 5'd3, 5'd8, 6'h26), 32'h10C, 32'h33, 32'h33, {5'd3, 5'd3}, 2'b10,
            {32'hB, 32'hA}, 1'b0, 1'b0,
            mk(0, 8'h26, 3'd1, 32'hB, 32'hB, 5'd8, 1, 0, 32'h10C, 0));
      // AND r9, r0, r0: r0 never forwarded
      drive(enc_r(5'd0, 5'd0, 5'd9, 6'h24), 32'h110, 32'h0, 32'h0, {5'd0, 5'd0}, 2'b01,
            {32'h0, 32'hFFFF}, 1'b0, 1'b0,
            mk(0, 8'h24, 3'd1, 32'h0, 32'h0, 5'd9, 1, 0, 32'h110, 0));
      // LUI r10, 0xABCD
      drive(enc_i(6'b001111, 5'd0, 5'd10, 16'hABCD), 32'h114, 32'h0, 32'h0, '0, 2'b00, '0,
            1'b0, 1'b0, mk(0, 8'h25, 3'd1, 32'h0, 32'hABCD_0000, 5'd10, 1, 0, 32'h114, 0));
      // LW r4, 8(r0)
      drive(enc_i(6'b100011, 5'd0, 5'd4, 16'h0008), 32'h200, 32'h0, 32'h0, '0, 2'b00, '0,
            1'b0, 1'b0, mk(0, 8'hE3, 3'd7, 32'h0, 32'h8, 5'd4, 1, 1, 32'h200, 0));
      // AND r5, r4, r6 right behind the load
      if (HazEn)
         drive(enc_r(5'd4, 5'd6, 5'd5, 6'h24), 32'h204, 32'h44, 32'h66, '0, 2'b00, '0,
               1'b0, 1'b0, mk(1, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h204, 0));
      else
         drive(enc_r(5'd4, 5'd6, 5'd5, 6'h24), 32'h204, 32'h44, 32'h66, '0, 2'b00, '0,
               1'b0, 1'b0, mk(0, 8'h24, 3'd1, 32'h44, 32'h66, 5'd5, 1, 0, 32'h204, 0));
      // Load now in MEM (slot 1)
      held = mk(0, 8'h24, 3'd1, 32'h4444, 32'h66, 5'd5, 1, 0, 32'h204, 0);
      drive(enc_r(5'd4, 5'd6, 5'd5, 6'h24), 32'h204, 32'h44, 32'h66, {5'd4, 5'd0}, 2'b10,
            {32'h4444, 32'h0}, 1'b0, 1'b0, held);
      // stall_i holds, then stall_i + flush_i loads a bubble
      drive(enc_i(6'b001101, 5'd0, 5'd11, 16'h5), 32'h208, 32'h0, 32'h0, '0, 2'b00, '0,
            1'b1, 1'b0, held);
      drive(enc_i(6'b001101, 5'd0, 5'd11, 16'h5), 32'h210, 32'h0, 32'h0, '0, 2'b00, '0,
            1'b1, 1'b1, mk(0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h210, 0));
      // unrecognised opcode
      drive({6'b111111, 26'h0}, 32'h300, 32'h12, 32'h34, '0, 2'b00, '0,
            1'b0, 1'b0, mk(0, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h300, 1));
      // LW r4, 0(r0), then OR r12, r4, r0 under stall_i
      held = mk(0, 8'hE3, 3'd7, 32'h0, 32'h0, 5'd4, 1, 1, 32'h304, 0);
      drive(enc_i(6'b100011, 5'd0, 5'd4, 16'h0), 32'h304, 32'h0, 32'h0, '0, 2'b00, '0,
            1'b0, 1'b0, held);
      held.stall = HazEn;
      drive(enc_r(5'd4, 5'd0, 5'd12, 6'h25), 32'h308, 32'h77, 32'h0, '0, 2'b00, '0,
            1'b1, 1'b0, held);
      if (HazEn)
         drive(enc_r(5'd4, 5'd0, 5'd12, 6'h25), 32'h308, 32'h77, 32'h0, '0, 2'b00, '0,
               1'b0, 1'b0, mk(1, 8'h0, 3'd0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h308, 0));
      else
         drive(enc_r(5'd4, 5'd0, 5'd12, 6'h25), 32'h308, 32'h77, 32'h0, '0, 2'b00, '0,
               1'b0, 1'b0, mk(0, 8'h25, 3'd1, 32'h77, 32'h0, 5'd12, 1, 0, 32'h308, 0));

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset in the middle of a cycle
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk("arst_pc",    ex_if.pc, 32'h0);
      chk("arst_wreg",  32'(ex_if.wreg), 32'd0);
      chk("arst_aluop", 32'(ex_if.aluop), 32'd0);
      chk("arst_load",  32'(ex_if.is_load), 32'd0);
      #13;
      rst = 1'b1;
      #1;
      chk("post_rst_stall", 32'(stallreq_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
